// File: rtl/rotate_pkg.sv
// rotate_pkg: shared FSM state type, default sizes and one-hot helpers for the rotate monitor.
package rotate_pkg;
  localparam int ROT_WIDTH = 4;
  localparam int ROT_STABLE_CYCLES = 4;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {ACQUIRE, TRACK, ERROR} state_t;
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return v != '0 && (v & (v - MAX_W'(1))) == '0;
  endfunction
  function automatic int onehot_index(input logic [MAX_W-1:0] v);
    onehot_index = 0;
    for (int i = 0; i < MAX_W; i++)
      if (v[i]) onehot_index = i;
  endfunction
endpackage

// File: rtl/rotate_filter.sv
// rotate_filter: two-flop synchroniser per line followed by a candidate/stability-count filter.
module rotate_filter #(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pattern_i,
  output logic [WIDTH-1:0] cand_o,
  output logic             stable_o
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, s_q, cand_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      s_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
    end else begin
      sync1_q <= pattern_i;
      s_q <= sync1_q;
      if (s_q != cand_q) begin
        cand_q <= s_q;
        cnt_q <= '0;
      end else if (cnt_q < CMAX) cnt_q <= cnt_q + CW'(1);
    end
  end
  assign cand_o = cand_q;
  assign stable_o = cnt_q == CMAX;
endmodule

// File: rtl/rotate_monitor.sv
// rotate_monitor: checks a filtered one-hot input pattern for left rotation; reports position,
// step pulses, a wrapping step count and a sticky protocol error.
module rotate_monitor
  import rotate_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH,
  parameter int STABLE_CYCLES = ROT_STABLE_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         pattern_in,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     step,
  output logic [CNT_W-1:0]         step_count,
  output logic                     err
);
  localparam int POS_W = $clog2(WIDTH);
  logic [WIDTH-1:0] cand, acc_q, acc_d, rot;
  logic stable, ev, hot;
  logic [POS_W-1:0] idx, pos_q, pos_d;
  logic pv_q, pv_d, step_q, step_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  rotate_filter #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk(clk),
    .rst_n(rst_n),
    .pattern_i(pattern_in),
    .cand_o(cand),
    .stable_o(stable)
  );
  assign rot = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
  assign ev = stable && cand != acc_q;
  assign hot = is_onehot(MAX_W'(cand));
  assign idx = POS_W'(onehot_index(MAX_W'(cand)));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    pos_d = pos_q;
    pv_d = pv_q;
    step_d = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    // Clear has priority over a coincident evaluation; the filter stays saturated so it re-evaluates next cycle.
    if (err_clr) begin
      state_d = ACQUIRE;
      acc_d = '0;
      pv_d = 1'b0;
      err_d = 1'b0;
    end else if (ev) begin
      acc_d = cand;
      case (state_q)
        ACQUIRE: begin
          if (hot) begin
            state_d = TRACK;
            pos_d = idx;
            pv_d = 1'b1;
          end else if (cand != '0) begin
            state_d = ERROR;
            pv_d = 1'b0;
            err_d = 1'b1;
          end
        end
        TRACK: begin
          if (cand == '0) begin
            state_d = ACQUIRE;
            pv_d = 1'b0;
          end else if (cand == rot) begin
            step_d = 1'b1;
            pos_d = idx;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = ERROR;
            pv_d = 1'b0;
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQUIRE;
      acc_q <= '0;
      pos_q <= '0;
      pv_q <= 1'b0;
      step_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      pos_q <= pos_d;
      pv_q <= pv_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign pos = pos_q;
  assign pos_valid = pv_q;
  assign step = step_q;
  assign step_count = cnt_q;
  assign err = err_q;
endmodule

// File: tb/tb_rotate_monitor.sv
// tb_rotate_monitor: scoreboard bench; each driven pattern pushes its expected outcome, due 7 edges later.
module tb_rotate_monitor;
  typedef enum int {M_ACQ, M_TRK, M_ERR} mstate_t;
  typedef struct {
    int         due;
    logic       st;
    logic [1:0] pos;
    logic       pv;
    logic       er;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic [3:0] pattern_in = 4'b0;
  logic [1:0] pos;
  logic pos_valid, step, err;
  logic [3:0] step_count;
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;
  exp_t sb[$];
  mstate_t mst = M_ACQ;
  logic [3:0] macc = 4'b0, mcnt = 4'b0;
  logic [1:0] mpos = 2'b0;
  logic mpv = 1'b0, merr = 1'b0, mstep;

  rotate_monitor #(.WIDTH(4), .STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pattern_in(pattern_in),
    .err_clr(err_clr),
    .pos(pos),
    .pos_valid(pos_valid),
    .step(step),
    .step_count(step_count),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic bit onehot4(input logic [3:0] v);
    return v == 4'b0001 || v == 4'b0010 || v == 4'b0100 || v == 4'b1000;
  endfunction

  // Reference protocol model for one accepted pattern.
  task automatic model(input logic [3:0] v);
    mstep = 1'b0;
    case (mst)
      M_ACQ:
        if (onehot4(v)) begin
          mst = M_TRK; mpv = 1'b1;
          mpos = v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
        end else if (v != 4'b0) begin
          mst = M_ERR; mpv = 1'b0; merr = 1'b1;
        end
      M_TRK:
        if (v == 4'b0) begin
          mst = M_ACQ; mpv = 1'b0;
        end else if (v == rotl(macc)) begin
          mstep = 1'b1; mpos = mpos + 2'd1; mcnt = mcnt + 4'd1;
        end else begin
          mst = M_ERR; mpv = 1'b0; merr = 1'b1;
        end
      default: ;
    endcase
    macc = v;
  endtask

  task automatic drive(input logic [3:0] v, input int hold);
    @(negedge clk);
    pattern_in = v;
    if (v != macc) begin
      model(v);
      sb.push_back('{cyc + 7, mstep, mpos, mpv, merr, mcnt});
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    mst = M_ACQ; macc = 4'b0; merr = 1'b0; mpv = 1'b0;
    sb.push_back('{cyc + 1, 1'b0, mpos, 1'b0, 1'b0, mcnt});
    if (pattern_in != 4'b0) begin
      model(pattern_in);
      sb.push_back('{cyc + 2, mstep, mpos, mpv, merr, mcnt});
    end
    @(negedge clk);
    err_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("step", step, e.st);
        check("pos", pos, e.pos);
        check("pos_valid", pos_valid, e.pv);
        check("err", err, e.er);
        check("step_count", step_count, e.cnt);
      end else if (step) check("step_idle", step, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pos", pos, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_step", step, 0);
    check("rst_count", step_count, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(4'b0001, 10);
    drive(4'b0010, 10);
    drive(4'b0100, 10);
    drive(4'b1000, 10);
    drive(4'b0001, 10);
    check("four_steps", step_count, 4);
    drive(4'b0010, 10);
    // Short glitch: must produce no event (monitor flags any stray step).
    @(negedge clk);
    pattern_in = 4'b0100;
    repeat (2) @(negedge clk);
    pattern_in = 4'b0010;
    repeat (12) @(negedge clk);
    check("glitch_pos", pos, 1);
    check("glitch_err", err, 0);
    drive(4'b0100, 10);
    drive(4'b0010, 10);
    check("reverse_err", err, 1);
    clear_err();
    check("clr_pos", pos, 1);
    check("clr_valid", pos_valid, 1);
    drive(4'b0100, 10);
    drive(4'b0011, 10);
    check("multi_err", err, 1);
    drive(4'b0000, 10);
    check("sticky_err", err, 1);
    clear_err();
    check("acq_valid", pos_valid, 0);
    drive(4'b0001, 10);
    do drive(rotl(pattern_in), 10); while (mcnt != 4'd0);
    check("wrap_count", step_count, 0);
    check("sb_empty", sb.size(), 0);
    drive(rotl(pattern_in), 4);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("arst_pos", pos, 0);
    check("arst_valid", pos_valid, 0);
    check("arst_step", step, 0);
    check("arst_count", step_count, 0);
    check("arst_err", err, 0);
    repeat (5) @(negedge clk);
    check("arst_hold_step", step, 0);
    check("arst_hold_count", step_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rotate_monitor.md
Name: rotate_monitor

Overview:
- Receive end of the rotating one-hot LED pattern: samples WIDTH asynchronous input lines driven by a rotating-pattern source, typically another board or the LED header loopback.
- Synchronises and filters the lines, then checks that each new pattern is the left-rotation of the previous one.
- Reports the current position, a per-step pulse, a wrapping step count and a sticky protocol error.
- Sits at the board-I/O boundary; its outputs feed status LEDs or a self-test checker.

Parameters:
- WIDTH, 4, number of pattern lines (>=2).
- STABLE_CYCLES, 4, consecutive equal synchronised samples required before a pattern is accepted (>=1).
- CNT_W, 16, width of step_count.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pattern_in  input  WIDTH  asynchronous pattern lines; bit 0 is the first position.
- err_clr  input  1  synchronous, single-cycle clear of the error condition.
- pos  output  clog2(WIDTH)  index of the set bit in the last accepted one-hot pattern.
- pos_valid  output  1  high while tracking a valid pattern.
- step  output  1  one-cycle pulse per correct forward rotation.
- step_count  output  CNT_W  number of correct steps, wraps modulo 2^CNT_W.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, all internal registers are 0, and the FSM is in ACQUIRE.
- Synchroniser: two flops per line (sync1 -> s). No logic between the two flops.
- Filter: candidate register cand, stability counter cnt, accepted register acc.
  - If s != cand: cand <= s and cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt increments.
  - cnt saturates at STABLE_CYCLES-1.
- Evaluate: occurs in any cycle where cnt == STABLE_CYCLES-1 and cand != acc.
  - acc <= cand.
  - FSM/output updates are registered and visible after the same edge.
- Latency: a clean pin change produces its step/pos update exactly STABLE_CYCLES+3 rising edges later.
- A glitch shorter than STABLE_CYCLES synchronised samples is never accepted. Returning to the old value before acceptance produces no event.
- FSM states: ACQUIRE, TRACK, ERROR.
  - ACQUIRE, evaluated pattern one-hot: go to TRACK, pos <= bit index, pos_valid <= 1, no step.
  - ACQUIRE, pattern all-zero: stay in ACQUIRE.
  - ACQUIRE, pattern multi-hot: go to ERROR.
  - TRACK, cand == {acc[WIDTH-2:0], acc[WIDTH-1]}: step pulse for 1 cycle, pos <= (pos+1) mod WIDTH, step_count increments (wraps). The transition from bit WIDTH-1 back to bit 0 is a valid step.
  - TRACK, pattern all-zero: go to ACQUIRE, pos_valid <= 0, pos holds its value, no error.
  - TRACK, any other one-hot (reverse rotation or a skip): go to ERROR.
  - TRACK, multi-hot: go to ERROR.
  - Entering ERROR: err <= 1, pos_valid <= 0.
  - ERROR: acc keeps updating on evaluation, but no step, pos or step_count changes.
- err_clr:
  - In any state: err <= 0, FSM goes to ACQUIRE, acc <= 0.
  - step_count and pos are not cleared.
  - err_clr coincident with an evaluate: err_clr wins and that evaluation is discarded. Because acc = 0 and cnt is still saturated, a stable non-zero cand is re-evaluated in the next cycle from ACQUIRE.
- step is never high for two consecutive cycles. Each evaluation requires acc to change, so at most one step occurs per accepted pattern.
- Reset mid-operation aborts immediately and returns all state to the reset values. No partial step is emitted.

Decomposition:
- Shared package rotate_pkg:
  - FSM state enum (ACQUIRE, TRACK, ERROR).
  - Default constants ROT_WIDTH=4 and ROT_STABLE_CYCLES=4.
  - A helper function onehot_index returning the set-bit index.
  - A helper function is_onehot.
- One sub-module: rotate_filter, containing the synchroniser plus the cand/cnt stability filter. It outputs cand and a stable flag.
- The FSM, position logic and counters stay in the top module.

Test Plan:
- Reset, then pattern_in = 0001 held -> after 7 edges: pos_valid=1, pos=0, step=0, err=0.
- Drive 0001, 0010, 0100, 1000, 0001, each held 10 cycles -> 4 step pulses. pos sequence 0,1,2,3,0. step_count=4. Each pulse 7 edges after its pin change.
- From TRACK at 0010, glitch to 0100 for 2 cycles then back to 0010 -> no step, pos stays 1, err=0.
- From TRACK at 0100, drive 0010 (reverse) -> err=1, pos_valid=0. Then pulse err_clr with 0010 held -> next cycle err=0. One cycle later pos_valid=1, pos=1, step_count unchanged.
- From TRACK, drive 0011 -> err=1. Drive 0000 -> err stays 1 (sticky). err_clr -> ACQUIRE, pos_valid=0.
- Preload step_count to 2^CNT_W-1 via 65535 steps (or CNT_W=4 build with 15 steps), then one more step -> step_count=0. Assert rst_n low mid-hold -> all outputs 0 asynchronously.
